audio_controller: RTL and testbench
===================================

# audio_controller

Drives a WM8731-style audio codec from the 50 MHz system clock. After reset it writes a fixed configuration over a two-wire (I2C) bus, then continuously streams a 24-bit mono sample to the codec DAC in I2S format. The same sample goes to both channels. It sits between the synth mixer (`mixer_output`) and the board codec pins.

## Interface
Parameters: none. All constants are fixed and live in the package.

Ports:
- `clk` in 1: 50 MHz system clock. One clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `SW0` in 1: output enable. 1 streams samples; 0 mutes (`DAC_DATA` = 0) while the clocks keep running.
- `mixer_output` in 24: signed two's-complement sample from the mixer.
- `SDIN` out 1: I2C data. Write-only; driven 1 when idle and during ack slots.
- `SCLK` out 1: I2C clock, 100 kHz.
- `USB_clk` out 1: codec MCLK, clk/4 = 12.5 MHz.
- `BCLK` out 1: bit clock, clk/16 = 3.125 MHz.
- `DAC_LR_CLK` out 1: frame clock, clk/1088 (about 45.96 kHz). Low = left channel, high = right channel.
- `DAC_DATA` out 1: serial DAC data, MSB first.

## Operation
- Free-running frame counter `fcnt` counts 0..1087 and wraps.
- All outputs are registered; each is a function of `fcnt` delayed by one clk:
  - `USB_clk` = `fcnt[1]`.
  - `BCLK` = `fcnt[3]`.
  - `DAC_LR_CLK` = (`fcnt` ≥ 544).
- Slot index `s` = (`fcnt` mod 544) / 16, range 0..33.
- Sample latch: `mixer_output` is latched when `fcnt` = 0, i.e. at the start of the left half-frame.
- I2S data placement:
  - Slots 1..24 carry bits 23..0 of the latched sample.
  - Slots 0 and 25..33 carry 0.
  - Identical data is sent in both halves.
- `DAC_DATA` is forced to 0 while configuration is incomplete or `SW0` = 0.
- Configuration FSM states: IDLE, START, SEND, STOP, GAP, DONE.
  - Sends 8 transactions. Each is: START, device byte 0x34, 16-bit word in two bytes MSB first, each byte followed by an ack clock, STOP.
  - Acks are not checked.
  - A 500-clk GAP follows each STOP.
  - Word order: 0x1E00 (reset), 0x0C07 (power), 0x0812 (DAC select), 0x0A00 (DAC unmute), 0x0E0A (I2S, 24-bit, slave), 0x1023 (USB mode, 44.1 setting), 0x0579 (headphone volume, both channels), 0x1201 (active).
  - After the eighth transaction the FSM enters DONE and stays there until reset.
- I2C bit timing:
  - One SCL period is 500 clk: low 250, high 250.
  - `SDIN` changes only mid-low.
  - START: `SDIN` falls while `SCLK` is high.
  - STOP: `SDIN` rises while `SCLK` is high.
- Reset values: `SCLK`=1, `SDIN`=1, `USB_clk`=0, `BCLK`=0, `DAC_LR_CLK`=0, `DAC_DATA`=0, `fcnt`=0, FSM=IDLE, latched sample=0.
- Reset mid-transaction or mid-frame aborts immediately to the reset values. Configuration restarts from word 0 after reset is released.

## Timing
- IDLE→START occurs 1 clk after reset deasserts.
- Each transaction lasts 29 SCL periods plus the gap, about 15 000 clk. DONE is reached in under 130 000 clk.
- Clocks run from the first cycle after reset; they are not gated by configuration.
- `DAC_DATA` bit changes coincide with the `BCLK` falling edge (`fcnt[3:0]` wrap). The codec samples on `BCLK` rising edges.
- Sample latency: the MSB of a sample latched at `fcnt`=0 appears 16 clk later (slot 1), +1 register stage.
- A `mixer_output` change mid-frame has no effect until the next `fcnt`=0.

## Structure
- Package `audio_pkg` holds:
  - divider constants: 1088, 544, 16, 500;
  - device address 0x34;
  - the 8-entry configuration word ROM;
  - the FSM state enum.
- Sub-module `i2c_writer` serializes one 24-bit transaction. Handshake: `start`/`busy`/`done` pulse, outputs `SCLK`/`SDIN`.
- The top level holds the sequencer, the clock counters and the I2S shifter.

## Test plan
- Reset held, then released: all outputs at reset values during reset. `BCLK` period 16 clk, `USB_clk` period 4 clk, `DAC_LR_CLK` period 1088 clk with 50% duty.
- I2C decode: capture `SDIN` on `SCLK` rising edges. The 8 transactions read `34 1E 00`, `34 0C 07`, … `34 12 01` in order, with START/STOP framing correct.
- `mixer_output` = 24'hA5C3F0, `SW0`=1, after DONE: left and right halves both serialize A5C3F0 in slots 1..24, with zeros elsewhere.
- `SW0`=0 after DONE: `DAC_DATA` stays 0 for a full frame while the clocks continue.
- `mixer_output` changes at `fcnt`=300: the current frame still carries the old value; the new value appears from the next frame.
- Reset asserted mid-configuration (third word): outputs return to reset values. After release, the first transaction is 0x1E00 again.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants, configuration ROM and sequencer state type
// for the WM8731 codec controller.
package audio_pkg;

    localparam int FRAME_LEN   = 1088;
    localparam int HALF_LEN    = 544;
    localparam int SLOT_LEN    = 16;
    localparam int SCL_PERIOD  = 500;
    localparam int SCL_HALF    = SCL_PERIOD / 2;
    localparam int GAP_LEN     = 500;
    localparam int CFG_WORDS   = 8;
    localparam int I2C_PERIODS = 29;

    localparam logic [7:0] DEV_ADDR = 8'h34;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        STOP,
        GAP,
        DONE
    } cfg_state_t;

    function automatic logic [15:0] cfg_word(input logic [2:0] idx);
        logic [15:0] w;
        case (idx)
            3'd0:    w = 16'h1E00;
            3'd1:    w = 16'h0C07;
            3'd2:    w = 16'h0812;
            3'd3:    w = 16'h0A00;
            3'd4:    w = 16'h0E0A;
            3'd5:    w = 16'h1023;
            3'd6:    w = 16'h0579;
            default: w = 16'h1201;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/i2c_writer.sv
// Two-wire write of one 24-bit transaction: START, three bytes
// each followed by an ack clock, STOP. Acks are not sampled.
module i2c_writer
    import audio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] data,
    output logic        busy,
    output logic        done,
    output logic        SCLK,
    output logic        SDIN
);

    localparam logic [8:0] C_LAST = 9'(SCL_PERIOD - 1);
    localparam logic [8:0] C_HALF = 9'(SCL_HALF);
    localparam logic [8:0] C_QTR  = 9'(SCL_HALF / 2);
    localparam logic [8:0] C_3QTR = 9'(SCL_HALF + SCL_HALF / 2);
    localparam logic [4:0] P_LAST = 5'(I2C_PERIODS - 1);

    logic [8:0]  cyc;
    logic [4:0]  per;
    logic [3:0]  bpos;
    logic [23:0] shreg;

    // Period 0 is START, 1..27 carry data/ack, the last is STOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            SCLK  <= 1'b1;
            SDIN  <= 1'b1;
            cyc   <= '0;
            per   <= '0;
            bpos  <= '0;
            shreg <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                SCLK <= 1'b1;
                SDIN <= 1'b1;
                if (start) begin
                    busy  <= 1'b1;
                    cyc   <= '0;
                    per   <= '0;
                    bpos  <= '0;
                    shreg <= data;
                end
            end else begin
                SCLK <= (per == 5'd0) || (cyc >= C_HALF);
                if (cyc == C_LAST) begin
                    cyc <= '0;
                    if (per == P_LAST) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        per <= per + 5'd1;
                    end
                end else begin
                    cyc <= cyc + 9'd1;
                end
                if (per == 5'd0) begin
                    if (cyc == C_HALF)
                        SDIN <= 1'b0;
                end else if (per == P_LAST) begin
                    if (cyc == C_QTR)
                        SDIN <= 1'b0;
                    else if (cyc == C_3QTR)
                        SDIN <= 1'b1;
                end else if (cyc == C_QTR) begin
                    if (bpos == 4'd8) begin
                        SDIN <= 1'b1;
                        bpos <= '0;
                    end else begin
                        SDIN  <= shreg[23];
                        shreg <= {shreg[22:0], 1'b0};
                        bpos  <= bpos + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/audio_controller.sv
// Codec controller: configuration sequencer over I2C, clock
// dividers and a mono 24-bit I2S DAC stream.
module audio_controller
    import audio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        SW0,
    input  logic [23:0] mixer_output,
    output logic        SDIN,
    output logic        SCLK,
    output logic        USB_clk,
    output logic        BCLK,
    output logic        DAC_LR_CLK,
    output logic        DAC_DATA
);

    localparam logic [10:0] F_LAST = 11'(FRAME_LEN - 1);
    localparam logic [10:0] F_HALF = 11'(HALF_LEN);
    localparam logic [8:0]  G_LAST = 9'(GAP_LEN - 1);
    localparam logic [2:0]  W_LAST = 3'(CFG_WORDS - 1);

    cfg_state_t  state;
    logic [2:0]  word_idx;
    logic [8:0]  gap_cnt;
    logic        wr_start;
    logic        wr_busy;
    logic        wr_done;

    logic [10:0] fcnt;
    logic [10:0] hcnt;
    logic [5:0]  slot;
    logic        slot_bit;
    logic [23:0] sample;

    i2c_writer u_i2c (
        .clk   (clk),
        .reset (reset),
        .start (wr_start),
        .data  ({DEV_ADDR, cfg_word(word_idx)}),
        .busy  (wr_busy),
        .done  (wr_done),
        .SCLK  (SCLK),
        .SDIN  (SDIN)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            word_idx <= '0;
            gap_cnt  <= '0;
            wr_start <= 1'b0;
        end else begin
            wr_start <= 1'b0;
            case (state)
                IDLE: state <= START;
                START: begin
                    if (!wr_busy) begin
                        wr_start <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (wr_done)
                        state <= STOP;
                end
                STOP: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == G_LAST) begin
                        if (word_idx == W_LAST) begin
                            state <= DONE;
                        end else begin
                            word_idx <= word_idx + 3'd1;
                            state    <= START;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 9'd1;
                    end
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Both half-frames carry the same slot layout.
    always_comb begin
        hcnt = (fcnt >= F_HALF) ? fcnt - F_HALF : fcnt;
        slot = 6'(hcnt / 11'(SLOT_LEN));
        slot_bit = 1'b0;
        if (slot >= 6'd1 && slot <= 6'd24)
            slot_bit = sample[5'(6'd24 - slot)];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt       <= '0;
            sample     <= '0;
            USB_clk    <= 1'b0;
            BCLK       <= 1'b0;
            DAC_LR_CLK <= 1'b0;
            DAC_DATA   <= 1'b0;
        end else begin
            fcnt <= (fcnt == F_LAST) ? '0 : fcnt + 11'd1;
            if (fcnt == '0)
                sample <= mixer_output;
            USB_clk    <= fcnt[1];
            BCLK       <= fcnt[3];
            DAC_LR_CLK <= (fcnt >= F_HALF);
            DAC_DATA   <= (state == DONE) && SW0 && slot_bit;
        end
    end

endmodule

// File: tb/tb_audio_controller.sv
// Self-checking bench: I2C bus decoder and I2S half-frame
// capture compared against values derived from the codec protocol.
module tb_audio_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        SW0 = 1'b0;
    logic [23:0] mixer_output = '0;
    logic        SDIN, SCLK, USB_clk, BCLK, DAC_LR_CLK, DAC_DATA;

    int vectors = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    audio_controller dut (
        .clk          (clk),
        .reset        (reset),
        .SW0          (SW0),
        .mixer_output (mixer_output),
        .SDIN         (SDIN),
        .SCLK         (SCLK),
        .USB_clk      (USB_clk),
        .BCLK         (BCLK),
        .DAC_LR_CLK   (DAC_LR_CLK),
        .DAC_DATA     (DAC_DATA)
    );

    logic [15:0] cfg_exp [8] = '{16'h1E00, 16'h0C07, 16'h0812, 16'h0A00,
                                 16'h0E0A, 16'h1023, 16'h0579, 16'h1201};

    // Bus decoder: START/STOP framing, bits taken on SCL rise.
    logic [27:0] i2c_q [$];
    int          i2c_n_q [$];
    logic        i_in_tx = 1'b0;
    int          i_nbits = 0;
    logic [27:0] i_sh = '0;
    logic        i_pscl = 1'b1;
    logic        i_psda = 1'b1;

    always @(negedge clk) begin
        if (reset) begin
            i_in_tx = 1'b0;
            i_nbits = 0;
        end else if (SCLK && i_pscl && i_psda && !SDIN) begin
            i_in_tx = 1'b1;
            i_nbits = 0;
            i_sh = '0;
        end else if (SCLK && i_pscl && !i_psda && SDIN) begin
            if (i_in_tx) begin
                i2c_q.push_back(i_sh);
                i2c_n_q.push_back(i_nbits);
            end
            i_in_tx = 1'b0;
        end else if (SCLK && !i_pscl && i_in_tx) begin
            i_sh = {i_sh[26:0], SDIN};
            i_nbits++;
        end
        i_pscl = SCLK;
        i_psda = SDIN;
    end

    // I2S capture: 34 bits per half-frame, restarted on LR change.
    typedef struct packed {
        logic        lr;
        logic [33:0] bits;
    } half_t;

    half_t       half_q [$];
    logic        s_pb = 1'b0;
    logic        s_lr = 1'b0;
    int          s_cnt = 0;
    logic [33:0] s_bits = '0;
    int          bclk_rises = 0;

    always @(negedge clk) begin
        if (reset) begin
            s_cnt = 0;
            s_lr = 1'b0;
        end else if (BCLK && !s_pb) begin
            bclk_rises++;
            if (DAC_LR_CLK != s_lr) begin
                s_lr = DAC_LR_CLK;
                s_cnt = 0;
            end
            if (s_cnt < 34) begin
                s_bits[s_cnt] = DAC_DATA;
                s_cnt++;
                if (s_cnt == 34)
                    half_q.push_back({s_lr, s_bits});
            end
        end
        s_pb = BCLK;
    end

    function automatic logic [23:0] half_value(input half_t h);
        logic [23:0] v = '0;
        for (int k = 1; k <= 24; k++)
            v = {v[22:0], h.bits[k]};
        return v;
    endfunction

    function automatic bit half_pad_zero(input half_t h);
        return (h.bits[0] == 1'b0) && (h.bits[33:25] == '0);
    endfunction

    function automatic logic pick(input int sel);
        case (sel)
            0:       return USB_clk;
            1:       return BCLK;
            default: return DAC_LR_CLK;
        endcase
    endfunction

    task automatic measure(input int sel, output int period, output int high);
        logic p, c;
        int r1, r2, f;
        r1 = -1; r2 = -1; f = -1;
        period = -1; high = -1;
        p = pick(sel);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            c = pick(sel);
            if (c && !p) begin
                if (r1 < 0) r1 = n;
                else r2 = n;
            end else if (!c && p && r1 >= 0 && f < 0) begin
                f = n;
            end
            p = c;
            if (r2 >= 0) break;
        end
        if (r2 >= 0 && f >= 0) begin
            period = r2 - r1;
            high = f - r1;
        end
    endtask

    task automatic wait_lr_fall(output bit ok);
        logic p;
        ok = 1'b0;
        p = DAC_LR_CLK;
        for (int n = 0; n < 1300; n++) begin
            @(negedge clk);
            if (p && !DAC_LR_CLK) begin
                ok = 1'b1;
                break;
            end
            p = DAC_LR_CLK;
        end
    endtask

    task automatic wait_halves(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 1300 * n; k++) begin
            @(negedge clk);
            if (half_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (SCLK !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_sclk: got %b want 1", SCLK);
        end
        vectors++;
        if (SDIN !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_sdin: got %b want 1", SDIN);
        end
        vectors++;
        if ({USB_clk, BCLK, DAC_LR_CLK, DAC_DATA} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_clocks: got %b want 0000",
                     {USB_clk, BCLK, DAC_LR_CLK, DAC_DATA});
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_clocks();
        int per, hi;
        int exp_per [3] = '{4, 16, 1088};
        for (int s = 0; s < 3; s++) begin
            measure(s, per, hi);
            vectors++;
            if (per !== exp_per[s]) begin
                miscompares++;
                $display("FAIL clk_period[%0d]: got %0d want %0d", s, per, exp_per[s]);
            end
            vectors++;
            if (hi !== exp_per[s] / 2) begin
                miscompares++;
                $display("FAIL clk_high[%0d]: got %0d want %0d", s, hi, exp_per[s] / 2);
            end
        end
    endtask

    task automatic check_tx(input int i, input logic [15:0] word);
        logic [27:0] sh;
        sh = i2c_q[i];
        vectors++;
        if (i2c_n_q[i] !== 28) begin
            miscompares++;
            $display("FAIL tx%0d_clocks: got %0d want 28", i, i2c_n_q[i]);
        end
        vectors++;
        if ({sh[27:20], sh[18:11], sh[9:2]} !== {8'h34, word}) begin
            miscompares++;
            $display("FAIL tx%0d_bytes: got %h want %h", i,
                     {sh[27:20], sh[18:11], sh[9:2]}, {8'h34, word});
        end
        vectors++;
        if ({sh[19], sh[10], sh[1]} !== 3'b111) begin
            miscompares++;
            $display("FAIL tx%0d_acks: got %b want 111", i, {sh[19], sh[10], sh[1]});
        end
    endtask

    task automatic test_config_reset();
        bit ok = 1'b0;
        for (int n = 0; n < 40000; n++) begin
            @(negedge clk);
            if (i2c_q.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL cfg_first_two: got %0d tx want 2", i2c_q.size());
        end else begin
            check_tx(0, cfg_exp[0]);
            check_tx(1, cfg_exp[1]);
        end
        repeat (3000) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({SCLK, SDIN, USB_clk, BCLK, DAC_LR_CLK, DAC_DATA} !== 6'b110000) begin
            miscompares++;
            $display("FAIL midcfg_reset_outs: got %b want 110000",
                     {SCLK, SDIN, USB_clk, BCLK, DAC_LR_CLK, DAC_DATA});
        end
        vectors++;
        if (i2c_q.size() != 2) begin
            miscompares++;
            $display("FAIL midcfg_partial: got %0d tx want 2", i2c_q.size());
        end
        repeat (20) @(posedge clk);
        i2c_q.delete();
        i2c_n_q.delete();
        #1 reset = 1'b0;
    endtask

    task automatic test_config();
        bit ok = 1'b0;
        for (int n = 0; n < 130000; n++) begin
            @(negedge clk);
            if (i2c_q.size() >= 8) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL cfg_all: got %0d tx want 8", i2c_q.size());
        end else begin
            for (int i = 0; i < 8; i++)
                check_tx(i, cfg_exp[i]);
        end
        repeat (16000) @(negedge clk);
        vectors++;
        if (i2c_q.size() != 8 || SCLK !== 1'b1 || SDIN !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_done_idle: got %0d tx scl %b sda %b want 8 1 1",
                     i2c_q.size(), SCLK, SDIN);
        end
    endtask

    task automatic test_stream();
        logic [23:0] smp;
        bit ok;
        SW0 = 1'b1;
        for (int it = 0; it < 6; it++) begin
            smp = (it == 0) ? 24'hA5C3F0 : 24'($urandom);
            mixer_output = smp;
            wait_lr_fall(ok);
            half_q.delete();
            if (ok) wait_halves(2, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL stream%0d_timeout: got %0d halves want 2", it, half_q.size());
            end else begin
                for (int h = 0; h < 2; h++) begin
                    vectors++;
                    if (half_q[h].lr !== 1'(h) || half_value(half_q[h]) !== smp) begin
                        miscompares++;
                        $display("FAIL stream%0d_half%0d: got lr %b %h want lr %0d %h",
                                 it, h, half_q[h].lr, half_value(half_q[h]), h, smp);
                    end
                    vectors++;
                    if (!half_pad_zero(half_q[h])) begin
                        miscompares++;
                        $display("FAIL stream%0d_pad%0d: got %b want zeros", it, h, half_q[h].bits);
                    end
                end
            end
        end
    endtask

    task automatic test_mute();
        bit ok;
        int r0, lr_edges;
        logic p;
        SW0 = 1'b0;
        mixer_output = 24'($urandom) | 24'h800001;
        wait_lr_fall(ok);
        half_q.delete();
        r0 = bclk_rises;
        lr_edges = 0;
        p = DAC_LR_CLK;
        repeat (1088) begin
            @(negedge clk);
            if (DAC_LR_CLK != p) lr_edges++;
            p = DAC_LR_CLK;
        end
        vectors++;
        if (bclk_rises - r0 != 68 || lr_edges != 2) begin
            miscompares++;
            $display("FAIL mute_clocks: got %0d bclk %0d lr want 68 2",
                     bclk_rises - r0, lr_edges);
        end
        wait_halves(2, ok);
        vectors++;
        if (!ok || half_q[0].bits !== '0 || half_q[1].bits !== '0) begin
            miscompares++;
            $display("FAIL mute_data: got ok %0d halves %0d want two zero halves",
                     ok, half_q.size());
        end
    endtask

    task automatic test_midframe_change();
        logic [23:0] old_s, new_s;
        bit ok;
        SW0 = 1'b1;
        old_s = 24'($urandom);
        new_s = old_s ^ (24'($urandom) | 24'h000100);
        mixer_output = old_s;
        wait_lr_fall(ok);
        half_q.delete();
        repeat (299) @(negedge clk);
        mixer_output = new_s;
        wait_halves(4, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL midframe_timeout: got %0d halves want 4", half_q.size());
        end else begin
            for (int h = 0; h < 4; h++) begin
                vectors++;
                if (half_value(half_q[h]) !== ((h < 2) ? old_s : new_s)) begin
                    miscompares++;
                    $display("FAIL midframe_half%0d: got %h want %h", h,
                             half_value(half_q[h]), (h < 2) ? old_s : new_s);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clocks();
        test_config_reset();
        test_config();
        test_stream();
        test_mute();
        test_midframe_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
